// File: rtl/wait_dispatcher_if.sv
// Script-side and wait-engine-side signals of wait_dispatcher.
// slave is the dispatcher's view, master the driver's view.
interface wait_dispatcher_if;
   logic        ms_tick;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic        abort;
   logic        is_ready;
   logic        wait_en;
   logic [7:0]  wait_num;
   logic [1:0]  wait_func;
   logic [2:0]  wait_sign;
   logic        step_done;
   logic        busy;
   logic [1:0]  err_code;

   modport slave (
      input  ms_tick, instr_valid, instr, abort, is_ready,
      output instr_ready, wait_en, wait_num, wait_func,
      output wait_sign, step_done, busy, err_code
   );

   modport master (
      output ms_tick, instr_valid, instr, abort, is_ready,
      input  instr_ready, wait_en, wait_num, wait_func,
      input  wait_sign, step_done, busy, err_code
   );
endinterface

// File: rtl/wait_dispatcher.sv
// Dispatches script wait/waituntil instructions to the wait engine,
// with settle blanking, ms timeout, abort and a sticky error code.
module wait_dispatcher #(
   parameter int TIMEOUT_MS    = 5000,
   parameter int SETTLE_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   wait_dispatcher_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_HOLD, S_DONE
   } state_t;

   localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_MS);
   localparam logic [3:0]  SC_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state_q;
   logic [15:0] instr_q;
   logic [3:0]  settle_q;
   logic [15:0] tmo_q;
   logic [15:0] tmo_d;
   logic        wait_en_q;
   logic        step_done_q;
   logic        busy_q;
   logic        instr_ready_q;
   logic [1:0]  err_q;
   logic [7:0]  wait_num_q;
   logic [1:0]  wait_func_q;
   logic [2:0]  wait_sign_q;
   logic [2:0]  op;
   logic [1:0]  func;

   assign op   = instr_q[15:13];
   assign func = instr_q[12:11];

   // saturating ms count, includes this cycle's tick
   always_comb begin
      tmo_d = tmo_q;
      if (tmo_q != 16'hFFFF)
         tmo_d = tmo_q + {15'd0, bus.ms_tick};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         instr_q       <= '0;
         settle_q      <= '0;
         tmo_q         <= '0;
         wait_en_q     <= 1'b0;
         step_done_q   <= 1'b0;
         busy_q        <= 1'b0;
         instr_ready_q <= 1'b1;
         err_q         <= 2'b00;
         wait_num_q    <= '0;
         wait_func_q   <= '0;
         wait_sign_q   <= '0;
      end else begin
         step_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  instr_q       <= bus.instr;
                  err_q         <= 2'b00;
                  instr_ready_q <= 1'b0;
                  busy_q        <= 1'b1;
                  state_q       <= S_LOAD;
               end
            end
            S_LOAD: begin
               settle_q <= '0;
               tmo_q    <= '0;
               if (op != 3'b011) begin
                  step_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (func[1]) begin
                  err_q       <= 2'b10;
                  step_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  wait_num_q  <= instr_q[7:0];
                  wait_func_q <= func;
                  wait_sign_q <= instr_q[10:8];
                  wait_en_q   <= 1'b1;
                  state_q     <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               tmo_q <= tmo_d;
               if (bus.abort) begin
                  wait_en_q   <= 1'b0;
                  err_q       <= 2'b11;
                  step_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (settle_q == SC_LAST) begin
                  state_q <= S_HOLD;
               end else begin
                  settle_q <= settle_q + 4'd1;
               end
            end
            S_HOLD: begin
               tmo_q <= tmo_d;
               // abort beats is_ready, is_ready beats timeout
               if (bus.abort) begin
                  wait_en_q   <= 1'b0;
                  err_q       <= 2'b11;
                  step_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (bus.is_ready) begin
                  wait_en_q   <= 1'b0;
                  step_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (tmo_d >= TO_LIM) begin
                  wait_en_q   <= 1'b0;
                  err_q       <= 2'b01;
                  step_done_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               instr_ready_q <= 1'b1;
               busy_q        <= 1'b0;
               state_q       <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.instr_ready = instr_ready_q;
   assign bus.wait_en     = wait_en_q;
   assign bus.wait_num    = wait_num_q;
   assign bus.wait_func   = wait_func_q;
   assign bus.wait_sign   = wait_sign_q;
   assign bus.step_done   = step_done_q;
   assign bus.busy        = busy_q;
   assign bus.err_code    = err_q;

endmodule

// File: tb/tb_wait_dispatcher.sv
// Directed bench for wait_dispatcher: small-timeout and default instances.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_wait_dispatcher;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   wait_dispatcher_if ifa ();
   wait_dispatcher_if ifb ();

   wait_dispatcher #(.TIMEOUT_MS(10), .SETTLE_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst), .bus(ifa.slave)
   );

   wait_dispatcher u_big (
      .clk(clk), .rst(rst), .bus(ifb.slave)
   );

   always #5 clk = ~clk;

   // returns at the falling edge right after the accepting edge (LOAD)
   task automatic send_a(input logic [15:0] v);
      @(negedge clk);
      ifa.instr_valid = 1'b1;
      ifa.instr       = v;
      @(negedge clk);
      ifa.instr_valid = 1'b0;
   endtask

   task automatic test_reset;
      total++;
      if (ifa.wait_en !== 1'b0 || ifa.busy !== 1'b0 ||
          ifa.step_done !== 1'b0 || ifa.err_code !== 2'b00) begin
         bad++;
         $display("FAIL rst_outs got=%b%b%b%b exp=0000",
                  ifa.wait_en, ifa.busy, ifa.step_done, ifa.err_code);
      end
      total++;
      if ({ifa.wait_num, ifa.wait_func, ifa.wait_sign} !== 13'd0) begin
         bad++;
         $display("FAIL rst_regs got=%h exp=0",
                  {ifa.wait_num, ifa.wait_func, ifa.wait_sign});
      end
      total++;
      if (ifa.instr_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_ready got=%b exp=1", ifa.instr_ready);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_wait_long;
      int drops;
      drops = 0;
      @(negedge clk);
      ifb.instr_valid = 1'b1;
      ifb.instr       = 16'h6005;
      @(negedge clk);
      ifb.instr_valid = 1'b0;
      ifb.ms_tick     = 1'b1;
      @(negedge clk);
      total++;
      if (ifb.wait_en !== 1'b1 || ifb.wait_num !== 8'h05 ||
          ifb.wait_func !== 2'b00 || ifb.busy !== 1'b1) begin
         bad++;
         $display("FAIL long_load en=%b num=%h func=%b busy=%b exp 1 05 00 1",
                  ifb.wait_en, ifb.wait_num, ifb.wait_func, ifb.busy);
      end
      repeat (498) begin
         @(negedge clk);
         if (ifb.wait_en !== 1'b1 || ifb.step_done !== 1'b0) drops++;
      end
      total++;
      if (drops != 0) begin
         bad++;
         $display("FAIL long_hold drops=%0d exp=0", drops);
      end
      ifb.is_ready = 1'b1;
      ifb.ms_tick  = 1'b0;
      @(negedge clk);
      ifb.is_ready = 1'b0;
      total++;
      if (ifb.step_done !== 1'b1 || ifb.wait_en !== 1'b0 ||
          ifb.err_code !== 2'b00 || ifb.wait_num !== 8'h05) begin
         bad++;
         $display("FAIL long_done sd=%b en=%b err=%b num=%h exp 1 0 00 05",
                  ifb.step_done, ifb.wait_en, ifb.err_code, ifb.wait_num);
      end
      @(negedge clk);
      total++;
      if (ifb.step_done !== 1'b0 || ifb.busy !== 1'b0) begin
         bad++;
         $display("FAIL long_once sd=%b busy=%b exp 0 0",
                  ifb.step_done, ifb.busy);
      end
   endtask

   task automatic test_settle;
      logic [3:0] sd;
      ifa.is_ready = 1'b1;
      send_a(16'h6A00);
      sd[0] = ifa.step_done;
      @(negedge clk);
      sd[1] = ifa.step_done;
      total++;
      if (ifa.wait_en !== 1'b1 || ifa.wait_func !== 2'b01 ||
          ifa.wait_sign !== 3'b010 || ifa.wait_num !== 8'h00) begin
         bad++;
         $display("FAIL settle_regs en=%b func=%b sign=%b num=%h exp 1 01 010 00",
                  ifa.wait_en, ifa.wait_func, ifa.wait_sign, ifa.wait_num);
      end
      @(negedge clk);
      sd[2] = ifa.step_done;
      @(negedge clk);
      sd[3] = ifa.step_done;
      total++;
      if (sd !== 4'b0000 || ifa.wait_en !== 1'b1) begin
         bad++;
         $display("FAIL settle_early sd=%b en=%b exp 0000 1", sd, ifa.wait_en);
      end
      @(negedge clk);
      ifa.is_ready = 1'b0;
      total++;
      if (ifa.step_done !== 1'b1 || ifa.wait_en !== 1'b0) begin
         bad++;
         $display("FAIL settle_lat sd=%b en=%b exp 1 0",
                  ifa.step_done, ifa.wait_en);
      end
      @(negedge clk);
   endtask

   task automatic run_ticks(input logic collide);
      send_a(16'h6000);
      repeat (3) @(negedge clk);
      for (int i = 1; i <= 10; i++) begin
         ifa.ms_tick = 1'b1;
         if (i == 10) ifa.is_ready = collide;
         @(negedge clk);
         if (i == 9) begin
            total++;
            if (ifa.wait_en !== 1'b1 || ifa.step_done !== 1'b0) begin
               bad++;
               $display("FAIL tick9 en=%b sd=%b exp 1 0",
                        ifa.wait_en, ifa.step_done);
            end
         end
      end
      ifa.ms_tick  = 1'b0;
      ifa.is_ready = 1'b0;
   endtask

   task automatic test_timeout;
      run_ticks(1'b0);
      total++;
      if (ifa.err_code !== 2'b01 || ifa.step_done !== 1'b1 ||
          ifa.wait_en !== 1'b0) begin
         bad++;
         $display("FAIL timeout err=%b sd=%b en=%b exp 01 1 0",
                  ifa.err_code, ifa.step_done, ifa.wait_en);
      end
      repeat (3) @(negedge clk);
      total++;
      if (ifa.err_code !== 2'b01 || ifa.busy !== 1'b0) begin
         bad++;
         $display("FAIL tmo_sticky err=%b busy=%b exp 01 0",
                  ifa.err_code, ifa.busy);
      end
   endtask

   task automatic test_collision;
      run_ticks(1'b1);
      total++;
      if (ifa.err_code !== 2'b00 || ifa.step_done !== 1'b1) begin
         bad++;
         $display("FAIL collide err=%b sd=%b exp 00 1",
                  ifa.err_code, ifa.step_done);
      end
      @(negedge clk);
   endtask

   task automatic test_other;
      logic en_seen;
      send_a(16'h7000);
      en_seen = ifa.wait_en;
      @(negedge clk);
      en_seen = en_seen | ifa.wait_en;
      total++;
      if (ifa.err_code !== 2'b10 || ifa.step_done !== 1'b1) begin
         bad++;
         $display("FAIL resv err=%b sd=%b exp 10 1",
                  ifa.err_code, ifa.step_done);
      end
      @(negedge clk);
      en_seen = en_seen | ifa.wait_en;
      total++;
      if (en_seen !== 1'b0 || ifa.err_code !== 2'b10) begin
         bad++;
         $display("FAIL resv_en en=%b err=%b exp 0 10", en_seen, ifa.err_code);
      end
      send_a(16'h2000);
      total++;
      if (ifa.step_done !== 1'b0 || ifa.err_code !== 2'b00) begin
         bad++;
         $display("FAIL skip_n0 sd=%b err=%b exp 0 00",
                  ifa.step_done, ifa.err_code);
      end
      @(negedge clk);
      total++;
      if (ifa.step_done !== 1'b1 || ifa.wait_en !== 1'b0) begin
         bad++;
         $display("FAIL skip_lat sd=%b en=%b exp 1 0",
                  ifa.step_done, ifa.wait_en);
      end
      @(negedge clk);
      total++;
      if (ifa.step_done !== 1'b0 || ifa.instr_ready !== 1'b1) begin
         bad++;
         $display("FAIL skip_end sd=%b rdy=%b exp 0 1",
                  ifa.step_done, ifa.instr_ready);
      end
   endtask

   task automatic test_abort;
      send_a(16'h6005);
      repeat (3) @(negedge clk);
      ifa.abort    = 1'b1;
      ifa.is_ready = 1'b1;
      @(negedge clk);
      ifa.abort    = 1'b0;
      ifa.is_ready = 1'b0;
      total++;
      if (ifa.err_code !== 2'b11 || ifa.step_done !== 1'b1 ||
          ifa.wait_en !== 1'b0) begin
         bad++;
         $display("FAIL abort err=%b sd=%b en=%b exp 11 1 0",
                  ifa.err_code, ifa.step_done, ifa.wait_en);
      end
      @(negedge clk);
      ifa.abort = 1'b1;
      repeat (2) @(negedge clk);
      ifa.abort = 1'b0;
      total++;
      if (ifa.busy !== 1'b0 || ifa.err_code !== 2'b11) begin
         bad++;
         $display("FAIL abort_idle busy=%b err=%b exp 0 11",
                  ifa.busy, ifa.err_code);
      end
   endtask

   task automatic test_back_to_back;
      logic [4:0] rdy;
      ifa.is_ready = 1'b1;
      @(negedge clk);
      ifa.instr_valid = 1'b1;
      ifa.instr       = 16'h6005;
      @(negedge clk);
      ifa.instr = 16'h2000;
      for (int i = 0; i < 5; i++) begin
         rdy[i] = ifa.instr_ready;
         if (i < 4) @(negedge clk);
      end
      total++;
      if (rdy !== 5'b00000 || ifa.step_done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_busy rdy=%b sd=%b exp 00000 1",
                  rdy, ifa.step_done);
      end
      @(negedge clk);
      total++;
      if (ifa.instr_ready !== 1'b1 || ifa.busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle rdy=%b busy=%b exp 1 0",
                  ifa.instr_ready, ifa.busy);
      end
      @(negedge clk);
      ifa.instr_valid = 1'b0;
      ifa.is_ready    = 1'b0;
      total++;
      if (ifa.busy !== 1'b1 || ifa.instr_ready !== 1'b0) begin
         bad++;
         $display("FAIL b2b_acc busy=%b rdy=%b exp 1 0",
                  ifa.busy, ifa.instr_ready);
      end
      @(negedge clk);
      total++;
      if (ifa.step_done !== 1'b1 || ifa.wait_en !== 1'b0) begin
         bad++;
         $display("FAIL b2b_skip sd=%b en=%b exp 1 0",
                  ifa.step_done, ifa.wait_en);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      send_a(16'h6005);
      repeat (3) @(negedge clk);
      total++;
      if (ifa.wait_en !== 1'b1) begin
         bad++;
         $display("FAIL mid_hold en=%b exp 1", ifa.wait_en);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (ifa.wait_en !== 1'b0 || ifa.busy !== 1'b0 ||
          ifa.err_code !== 2'b00 || ifa.wait_num !== 8'h00 ||
          ifa.instr_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_rst en=%b busy=%b err=%b num=%h rdy=%b exp 0 0 00 00 1",
                  ifa.wait_en, ifa.busy, ifa.err_code, ifa.wait_num,
                  ifa.instr_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (ifa.instr_ready !== 1'b1 || ifa.step_done !== 1'b0) begin
         bad++;
         $display("FAIL post_rst rdy=%b sd=%b exp 1 0",
                  ifa.instr_ready, ifa.step_done);
      end
   endtask

   initial begin
      clk   = 1'b0;
      rst   = 1'b1;
      total = 0;
      bad   = 0;
      ifa.ms_tick = 1'b0; ifa.instr_valid = 1'b0; ifa.instr = '0;
      ifa.abort   = 1'b0; ifa.is_ready    = 1'b0;
      ifb.ms_tick = 1'b0; ifb.instr_valid = 1'b0; ifb.instr = '0;
      ifb.abort   = 1'b0; ifb.is_ready    = 1'b0;
      repeat (2) @(negedge clk);
      test_reset;
      test_wait_long;
      test_settle;
      test_timeout;
      test_collision;
      test_other;
      test_abort;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
